store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  Committed-store queue sitting directly upstream of stor_mem's single write port (wen/waddr/wdata).
//  Accepts stores in commit order from the ROB retire logic, drains one per cycle into stor_mem in FIFO order.
//  Provides a load-lookup port so the load path sees stores not yet written to stor_mem.
// PARAMETERS
//  DEPTH     8             number of entries; power of two, >= 2
//  PTR_BITS  $clog2(DEPTH) index width; derived, not overridden
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  enq_valid  in   1      ROB presents a committed store
//  enq_ready  out  1      buffer can accept (= !full)
//  enq_addr   in   15     word address [15:1]
//  enq_data   in   16     store data
//  mem_hold   in   1      when 1, draining is blocked this cycle
//  mem_wen    out  1      write enable to stor_mem
//  mem_waddr  out  15     write address to stor_mem [15:1]
//  mem_wdata  out  16     write data to stor_mem
//  ld_addr    in   15     load lookup word address [15:1]
//  ld_hit     out  1      a buffered store matches ld_addr
//  ld_data    out  16     data of youngest matching store
//  empty      out  1      count == 0
//  count      out  PTR_BITS+1  valid entry count, 0..DEPTH
// BEHAVIOUR
//  - State: entry array, head/tail pointers of PTR_BITS+1 bits (MSB = wrap bit), count register.
//  - full = (head[PTR_BITS-1:0]==tail[PTR_BITS-1:0]) && (head MSB != tail MSB); empty = pointers equal.
//  - Reset (synchronous, rst=1 at posedge): head=tail=0, count=0; hence mem_wen=0, ld_hit=0, empty=1, enq_ready=1.
//    Entry contents not reset. rst overrides enq and drain in the same cycle; in-flight stores are discarded.
//  - Enqueue: enq_valid & enq_ready at posedge -> entry[tail]={addr,data}, tail++.
//  - enq_ready = !full only; a drain in the same cycle does NOT make a full buffer ready (no bypass).
//  - Drain: mem_wen = !empty & !mem_hold; mem_waddr/mem_wdata = entry[head] (decoded from registers, no comb path
//    from enq_*). When mem_wen=1, head++ at the same posedge that stor_mem captures the write.
//  - Latency: store enqueued at edge N is on mem_* during cycle N+1 at earliest; never same cycle.
//  - Simultaneous enq+drain: count unchanged, both pointers advance. Pointers wrap modulo 2*DEPTH.
//  - mem_hold=1: mem_wen=0, state frozen apart from enqueue; ld lookup still active.
//  - Lookup (comb): scan valid entries head..tail-1; ld_hit=1 if any addr==ld_addr; ld_data = youngest (closest to
//    tail) match. Head entry being drained this cycle still matches. Store enqueued this cycle not visible until next.
//  - ld_data = 16'h0000 when ld_hit=0.
// CONFIGURATION
//  STORE_BUF_FWD_EN defined: lookup as above (store-to-load forwarding).
//  STORE_BUF_FWD_EN undefined: ld_hit=1 means "conflict, stall load"; ld_data tied 16'h0000; the load unit
//  retries until the matching store has drained. Match logic identical in both builds.
// STRUCTURE
//  mem_pkg: ADDR_W=15, DATA_W=16, typedef stb_entry_t {logic [ADDR_W:1] addr; logic [DATA_W-1:0] data;}.
//  Sub-module stb_cam: per-entry valid mask + address compare + youngest-first priority select
//  (inputs entries, head, tail, ld_addr; outputs hit, index). store_buffer holds pointers and drain logic.
// TESTING
//  1 Reset: hold rst 2 cycles mid-traffic -> empty=1, count=0, mem_wen=0, ld_hit=0 next cycle; prior stores never drain.
//  2 Single store: enq {0x0002, 0x0032} -> mem_wen=1, waddr=0x0002, wdata=0x0032 next cycle; stor_mem rdata1 reads 0x0032.
//  3 Ordering: enq 0x0002<-0x0032 then 0x0002<-0x0030 on back-to-back cycles -> two writes in order, final read 0x0030.
//  4 Full: mem_hold=1, enq 8 stores -> enq_ready=0, count=8; 9th enq_valid ignored; release hold -> 8 writes, wrap ok.
//  5 Forwarding (FWD_EN): two stores to 0x0010 (0x1111, 0x2222), mem_hold=1, ld_addr=0x0010 -> ld_hit=1, ld_data=0x2222;
//    miss address 0x0011 -> ld_hit=0, ld_data=0.
//  6 No-FWD build: same as 5 -> ld_hit=1, ld_data=0; ld_hit drops the cycle after the last 0x0010 store drains.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the store buffer and its lookup CAM.
package mem_pkg;

   localparam int ADDR_W = 15;   // word address, bits [15:1]
   localparam int DATA_W = 16;

   typedef struct packed {
      logic [ADDR_W:1]   addr;
      logic [DATA_W-1:0] data;
   } stb_entry_t;

endpackage

// File: rtl/stb_cam.sv
// Load-lookup CAM for the store buffer: marks the occupied slots between
// head and tail, compares their addresses against the load address and
// returns the youngest (closest to tail) matching slot.
module stb_cam
   import mem_pkg::*;
#(
   parameter  int DEPTH    = 8,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0][ADDR_W:1] entry_addr_i,
   input  logic [PTR_BITS:0]          head_i,
   input  logic [PTR_BITS:0]          tail_i,
   input  logic [ADDR_W:1]            ld_addr_i,
   output logic                       hit_o,
   output logic [PTR_BITS-1:0]        index_o
);

   logic [PTR_BITS:0]   occ;
   logic [PTR_BITS-1:0] idx;

   // Walk slots oldest to youngest; a later match overrides, so the youngest wins.
   always_comb begin
      occ     = tail_i - head_i;
      idx     = '0;
      hit_o   = 1'b0;
      index_o = head_i[PTR_BITS-1:0];
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i[PTR_BITS-1:0] + k[PTR_BITS-1:0];
         if (((PTR_BITS+1)'(k) < occ) && (entry_addr_i[idx] == ld_addr_i)) begin
            hit_o   = 1'b1;
            index_o = idx;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO in front of stor_mem's write port. Drains one store
// per cycle in order and exposes a load lookup over the undrained stores.
// Build option STORE_BUF_FWD_EN: when defined, ld_data forwards the youngest
// matching store; otherwise ld_hit only signals a conflict and ld_data is 0.
module store_buffer
   import mem_pkg::*;
#(
   parameter  int DEPTH    = 8,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enq_valid,
   output logic              enq_ready,
   input  logic [ADDR_W:1]   enq_addr,
   input  logic [DATA_W-1:0] enq_data,
   input  logic              mem_hold,
   output logic              mem_wen,
   output logic [ADDR_W:1]   mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [ADDR_W:1]   ld_addr,
   output logic              ld_hit,
   output logic [DATA_W-1:0] ld_data,
   output logic              empty,
   output logic [PTR_BITS:0] count
);

   stb_entry_t                entry_q [DEPTH];
   logic [PTR_BITS:0]         head_q, head_d;
   logic [PTR_BITS:0]         tail_q, tail_d;
   logic [PTR_BITS:0]         count_q, count_d;
   logic                      full;
   logic                      do_enq;
   logic [DEPTH-1:0][ADDR_W:1] entry_addr;
   logic [PTR_BITS-1:0]       cam_idx;

   // Wrap bit distinguishes full from empty when the index bits coincide.
   assign full      = (head_q[PTR_BITS-1:0] == tail_q[PTR_BITS-1:0]) &&
                      (head_q[PTR_BITS] != tail_q[PTR_BITS]);
   assign empty     = (head_q == tail_q);
   assign enq_ready = !full;
   assign do_enq    = enq_valid && !full;
   assign count     = count_q;

   // Drain port reads only registered state; a new store cannot reach it the same cycle.
   assign mem_wen   = !empty && !mem_hold;
   assign mem_waddr = entry_q[head_q[PTR_BITS-1:0]].addr;
   assign mem_wdata = entry_q[head_q[PTR_BITS-1:0]].data;

   // Next-state for pointers and occupancy.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (do_enq)  tail_d = tail_q + 1'b1;
      if (mem_wen) head_d = head_q + 1'b1;
      case ({do_enq, mem_wen})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset discards anything still buffered.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage, written at tail; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst && do_enq)
         entry_q[tail_q[PTR_BITS-1:0]] <= '{addr: enq_addr, data: enq_data};
   end

   // Flatten entry addresses for the CAM.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) entry_addr[i] = entry_q[i].addr;
   end

   stb_cam #(.DEPTH(DEPTH)) u_cam (
      .entry_addr_i (entry_addr),
      .head_i       (head_q),
      .tail_i       (tail_q),
      .ld_addr_i    (ld_addr),
      .hit_o        (ld_hit),
      .index_o      (cam_idx)
   );

`ifdef STORE_BUF_FWD_EN
   assign ld_data = ld_hit ? entry_q[cam_idx].data : '0;
`else
   // Conflict-only lookup: the load unit stalls on ld_hit, no data is forwarded.
   logic unused_cam_idx;
   assign unused_cam_idx = ^cam_idx;
   assign ld_data        = '0;
`endif

endmodule
